// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchroniser, per-key debouncer and edge detector for push-button pins
//
// Purpose: conditions raw, asynchronous, bouncing key pins into clean
// per-key levels, one-cycle press/release pulses and a pin-polarity
// debounced bus for the processor key PIO.
//
// Ports:
//   clk_clk            in   1            system clock
//   reset_reset        in   1            synchronous, active-high reset
//   key_raw            in   NUM_KEYS     raw key pins (asynchronous)
//   key_stable         out  NUM_KEYS     debounced level, 1 = pressed
//   key_press_pulse    out  NUM_KEYS     one-cycle pulse when key_stable rises
//   key_release_pulse  out  NUM_KEYS     one-cycle pulse when key_stable falls
//   key_export         out  NUM_KEYS     debounced level in pin polarity
//   press_count        out  8*NUM_KEYS   per-key press counters, key i at [8i+7:8i]
//
// Optional feature macro: KEY_DEBOUNCE_PRESS_CNT_EN
//   defined   - an 8-bit wrapping press counter per key drives press_count
//   undefined - press_count is constant 0 and no counter flops exist

module key_debounce #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic [NUM_KEYS-1:0]     key_raw,
    output logic [NUM_KEYS-1:0]     key_stable,
    output logic [NUM_KEYS-1:0]     key_press_pulse,
    output logic [NUM_KEYS-1:0]     key_release_pulse,
    output logic [NUM_KEYS-1:0]     key_export,
    output logic [8*NUM_KEYS-1:0]   press_count
);

    // Pin level of a key that is not pressed.
    localparam logic PIN_UNPRESSED = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic             sync1_q;
        logic             sync2_q;
        logic             key_sync;
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             stable_q;
        logic             stable_d;
        logic             press_q;
        logic             press_d;
        logic             release_q;
        logic             release_d;
        logic             export_q;
        logic             export_d;

        // Normalise the synchronised pin so that 1 always means pressed.
        assign key_sync = (KEY_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            stable_d  = stable_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (key_sync != stable_q) begin
                        state_d = S_COUNT;
                        cnt_d   = CNT_ONE;
                    end
                end
                S_COUNT: begin
                    if (key_sync == stable_q) begin
                        // Input went back before qualifying: treat as a glitch.
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        stable_d  = key_sync;
                        press_d   = key_sync;
                        release_d = ~key_sync;
                        state_d   = S_IDLE;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
            // Derived from the next level so the export bus changes together
            // with key_stable rather than a cycle later.
            export_d = (KEY_ACTIVE_LOW != 0) ? ~stable_d : stable_d;
        end

        always_ff @(posedge clk_clk) begin
            if (reset_reset) begin
                sync1_q   <= PIN_UNPRESSED;
                sync2_q   <= PIN_UNPRESSED;
                state_q   <= S_IDLE;
                cnt_q     <= '0;
                stable_q  <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                export_q  <= PIN_UNPRESSED;
            end else begin
                sync1_q   <= key_raw[i];
                sync2_q   <= sync1_q;
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                stable_q  <= stable_d;
                press_q   <= press_d;
                release_q <= release_d;
                export_q  <= export_d;
            end
        end

        assign key_stable[i]        = stable_q;
        assign key_press_pulse[i]   = press_q;
        assign key_release_pulse[i] = release_q;
        assign key_export[i]        = export_q;

`ifdef KEY_DEBOUNCE_PRESS_CNT_EN
        logic [7:0] pcnt_q;

        always_ff @(posedge clk_clk) begin
            if (reset_reset) begin
                pcnt_q <= 8'h00;
            end else if (press_q) begin
                pcnt_q <= pcnt_q + 8'h01;
            end
        end

        assign press_count[8*i +: 8] = pcnt_q;
`else
        assign press_count[8*i +: 8] = 8'h00;
`endif
    end : g_key

endmodule : key_debounce

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed self-checking bench for key_debounce

module tb_key_debounce;

    localparam int NK = 4;

    logic          clk_clk;
    logic          reset_reset;
    logic [NK-1:0] key_raw;
    logic [NK-1:0] key_stable;
    logic [NK-1:0] key_press_pulse;
    logic [NK-1:0] key_release_pulse;
    logic [NK-1:0] key_export;
    logic [8*NK-1:0] press_count;

    int tests;
    int fails;
    int seen_press;
    int seen_release;

    key_debounce #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (16),
        .CNT_W           (5),
        .KEY_ACTIVE_LOW  (1)
    ) dut (
        .clk_clk           (clk_clk),
        .reset_reset       (reset_reset),
        .key_raw           (key_raw),
        .key_stable        (key_stable),
        .key_press_pulse   (key_press_pulse),
        .key_release_pulse (key_release_pulse),
        .key_export        (key_export),
        .press_count       (press_count)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    // Advance n cycles, counting cycles where any pulse bit was high.
    task automatic step_watch(input int n);
        seen_press   = 0;
        seen_release = 0;
        repeat (n) begin
            @(negedge clk_clk);
            if (key_press_pulse != '0) seen_press++;
            if (key_release_pulse != '0) seen_release++;
        end
    endtask

    task automatic press_release_key3;
        key_raw = 4'h7;
        step(19);
        key_raw = 4'hF;
        step(20);
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        key_raw     = 4'hF;
        reset_reset = 1'b1;
        step(2);
        reset_reset = 1'b0;

        // 1. reset state
        check("rst_stable", 32'(key_stable), 32'h0);
        check("rst_export", 32'(key_export), 32'hF);
        check("rst_press", 32'(key_press_pulse), 32'h0);
        check("rst_release", 32'(key_release_pulse), 32'h0);
        check("rst_count", press_count, 32'h0);
        step_watch(5);
        check("idle_no_pulse", 32'(seen_press + seen_release), 32'd0);

        // 2. key 0 press: the 19th edge after the change is T+18
        key_raw = 4'hE;
        step_watch(18);
        check("p0_early_stable", 32'(key_stable), 32'h0);
        check("p0_early_pulse", 32'(seen_press), 32'd0);
        step(1);
        check("p0_stable", 32'(key_stable), 32'h1);
        check("p0_pulse", 32'(key_press_pulse), 32'h1);
        check("p0_export", 32'(key_export), 32'hE);
        check("p0_no_rel", 32'(key_release_pulse), 32'h0);
        step(1);
        check("p0_pulse_one_cycle", 32'(key_press_pulse), 32'h0);
        check("p0_stable_held", 32'(key_stable), 32'h1);
        key_raw = 4'hF;
        step(18);
        check("r0_early", 32'(key_stable), 32'h1);
        step(1);
        check("r0_pulse", 32'(key_release_pulse), 32'h1);
        check("r0_stable", 32'(key_stable), 32'h0);
        check("r0_export", 32'(key_export), 32'hF);
        step(1);
        check("r0_pulse_one_cycle", 32'(key_release_pulse), 32'h0);

        // 3. key 1 bounces every 5 cycles for 100 cycles, then held low
        for (int p = 0; p < 20; p++) begin
            key_raw[1] = ~key_raw[1];
            step_watch(5);
            if (seen_press != 0 || seen_release != 0)
                check("bounce_quiet", 32'(seen_press + seen_release), 32'd0);
        end
        check("bounce_stable", 32'(key_stable), 32'h0);
        key_raw[1] = 1'b0;
        step_watch(18);
        check("bounce_settle_quiet", 32'(seen_press), 32'd0);
        step(1);
        check("bounce_press", 32'(key_press_pulse), 32'h2);
        step(1);
        check("bounce_press_once", 32'(key_press_pulse), 32'h0);
        key_raw = 4'hF;
        step(20);
        check("bounce_released", 32'(key_stable), 32'h0);

        // 4. key 0 low over 16 sampling edges is rejected, over 17 accepted
        key_raw = 4'hE;
        step(16);
        key_raw = 4'hF;
        step_watch(25);
        check("short_no_pulse", 32'(seen_press + seen_release), 32'd0);
        check("short_stable", 32'(key_stable), 32'h0);
        check("short_export", 32'(key_export), 32'hF);
        key_raw = 4'hE;
        step(17);
        key_raw = 4'hF;
        step(2);
        check("boundary_press", 32'(key_press_pulse), 32'h1);
        check("boundary_stable", 32'(key_stable), 32'h1);
        step(20);
        check("boundary_released", 32'(key_stable), 32'h0);

        // 5. two keys at once, then release one
        key_raw = 4'h3;
        step_watch(18);
        check("multi_early", 32'(seen_press), 32'd0);
        step(1);
        check("multi_press", 32'(key_press_pulse), 32'hC);
        check("multi_stable", 32'(key_stable), 32'hC);
        check("multi_export", 32'(key_export), 32'h3);
        step(1);
        check("multi_press_once", 32'(key_press_pulse), 32'h0);
        key_raw = 4'h7;
        step(19);
        check("k2_release", 32'(key_release_pulse), 32'h4);
        check("k2_stable", 32'(key_stable), 32'h8);
        check("k2_export", 32'(key_export), 32'h7);
        check("k2_no_press", 32'(key_press_pulse), 32'h0);
        key_raw = 4'hF;
        step(20);
        check("multi_released", 32'(key_stable), 32'h0);

        // 6. reset 10 cycles into a qualification discards it
        key_raw = 4'hE;
        step(10);
        reset_reset = 1'b1;
        step(1);
        reset_reset = 1'b0;
        check("midrst_stable", 32'(key_stable), 32'h0);
        check("midrst_press", 32'(key_press_pulse), 32'h0);
        check("midrst_export", 32'(key_export), 32'hF);
        step_watch(18);
        check("midrst_no_pulse", 32'(seen_press), 32'd0);
        step(1);
        check("requal_press", 32'(key_press_pulse), 32'h1);
        key_raw = 4'hF;
        step(20);
        check("requal_released", 32'(key_stable), 32'h0);

`ifdef KEY_DEBOUNCE_PRESS_CNT_EN
        check("pcnt_after_rst", press_count, 32'h0000_0001);
        for (int n = 0; n < 255; n++) press_release_key3();
        check("pcnt_255", 32'(press_count[31:24]), 32'd255);
        press_release_key3();
        check("pcnt_wrap", 32'(press_count[31:24]), 32'd0);
        check("pcnt_key0", 32'(press_count[7:0]), 32'd1);
`else
        press_release_key3();
        check("pcnt_tied_zero", press_count, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_key_debounce
